// File: rtl/fpsr_pkg.sv
// Shared constants, types and helpers for the FPSR game/quiz sequencer.
package fpsr_pkg;

    // One-hot state bit positions; quiz and game states are consecutive so that
    // "advance" is a left shift of the state vector.
    localparam int ST_INIT = 0;
    localparam int ST_Q1   = 1;
    localparam int ST_Q2   = 2;
    localparam int ST_Q3   = 3;
    localparam int ST_G1   = 4;
    localparam int ST_G2   = 5;
    localparam int ST_G3   = 6;
    localparam int ST_DONE = 7;
    localparam int NUM_ST  = 8;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_RIGHT = 2'd1,
        DIR_DOWN  = 2'd2,
        DIR_LEFT  = 2'd3
    } dir_e;

    localparam int SCORE_W = 8;
    typedef logic [SCORE_W-1:0] score_t;

    // Unsigned add that clamps at the all-ones score instead of wrapping.
    function automatic score_t sat_add(input score_t a, input logic [1:0] inc);
        logic [SCORE_W:0] sum;
        sum = {1'b0, a} + {{(SCORE_W-1){1'b0}}, inc};
        return sum[SCORE_W] ? {SCORE_W{1'b1}} : sum[SCORE_W-1:0];
    endfunction

endpackage

// File: rtl/fpsr_seq_checker.sv
// Tracks progress through one game's move list and flags completion or forfeit.
module fpsr_seq_checker
    import fpsr_pkg::*;
#(
    parameter int SEQ_LEN  = 4,
    parameter int MAX_MISS = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear,
    input  logic                 move_valid,
    input  dir_e                 move_code,
    input  logic [2*SEQ_LEN-1:0] seq,
    output logic                 seq_done,
    output logic                 forfeit
);

    localparam int IDX_W  = (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1;
    localparam int MISS_W = $clog2(MAX_MISS + 1);

    logic [IDX_W-1:0]  move_idx;
    logic [MISS_W-1:0] miss_cnt;
    logic [1:0]        want;
    logic              hit;
    logic              last;

    always_comb begin
        want     = seq[{move_idx, 1'b0} +: 2];
        hit      = move_valid && (2'(move_code) == want);
        last     = (move_idx == IDX_W'(SEQ_LEN - 1));
        seq_done = hit && last;
        forfeit  = move_valid && !hit && (miss_cnt == MISS_W'(MAX_MISS - 1));
    end

    // NOTE: reset is sampled only at the clock edge, so it sits inside the
    // clocked block with no reset term in the sensitivity list; all state
    // updates use non-blocking assignments so every flop sees pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            move_idx <= '0;
            miss_cnt <= '0;
        end else if (move_valid) begin
            if (hit) begin
                if (last) begin
                    move_idx <= '0;
                    miss_cnt <= '0;
                end else begin
                    move_idx <= move_idx + 1'b1;
                end
            end else begin
                move_idx <= '0;
                miss_cnt <= forfeit ? '0 : miss_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/fpsr_game_fsm.sv
// FPSR quiz/game sequencer: one-hot state flags for the VGA overlays plus a
// saturating player score.
module fpsr_game_fsm
    import fpsr_pkg::*;
#(
    parameter logic [15:0]          ANS_Q1   = 16'h0005,
    parameter logic [15:0]          ANS_Q2   = 16'h00A0,
    parameter logic [15:0]          ANS_Q3   = 16'h8001,
    parameter int                   SEQ_LEN  = 4,
    parameter logic [2*SEQ_LEN-1:0] SEQ_G1   = 8'b00_01_10_11,
    parameter logic [2*SEQ_LEN-1:0] SEQ_G2   = 8'b11_11_00_01,
    parameter logic [2*SEQ_LEN-1:0] SEQ_G3   = 8'b10_00_11_01,
    parameter int                   MAX_MISS = 3
) (
    input  logic               ClkPort,
    input  logic               Reset_n,
    input  logic               btn_c,
    input  logic               up,
    input  logic               right,
    input  logic               down,
    input  logic               left,
    input  logic [15:0]        sw,
    output logic               q_Init,
    output logic               q_Q1,
    output logic               q_Q2,
    output logic               q_Q3,
    output logic               q_G1,
    output logic               q_G2,
    output logic               q_G3,
    output logic               q_Done,
    output logic               sw_ok,
    output logic [SCORE_W-1:0] score
);

    localparam logic [NUM_ST-1:0] S_INIT = NUM_ST'(1) << ST_INIT;
    localparam logic [NUM_ST-1:0] S_Q1   = NUM_ST'(1) << ST_Q1;
    localparam logic [NUM_ST-1:0] S_Q2   = NUM_ST'(1) << ST_Q2;
    localparam logic [NUM_ST-1:0] S_Q3   = NUM_ST'(1) << ST_Q3;
    localparam logic [NUM_ST-1:0] S_G1   = NUM_ST'(1) << ST_G1;
    localparam logic [NUM_ST-1:0] S_G2   = NUM_ST'(1) << ST_G2;
    localparam logic [NUM_ST-1:0] S_G3   = NUM_ST'(1) << ST_G3;
    localparam logic [NUM_ST-1:0] S_DONE = NUM_ST'(1) << ST_DONE;

    logic [NUM_ST-1:0]    state;
    logic [NUM_ST-1:0]    state_n;
    score_t               score_n;
    logic [3:0]           dirs;
    logic                 in_game;
    logic                 move_single;
    logic                 move_valid;
    dir_e                 move_code;
    logic [2*SEQ_LEN-1:0] seq_sel;
    logic                 quiz_ok;
    logic                 seq_done;
    logic                 forfeit;

    assign dirs        = {left, down, right, up};
    assign in_game     = state[ST_G1] | state[ST_G2] | state[ST_G3];
    assign move_single = (dirs != 4'd0) && ((dirs & (dirs - 4'd1)) == 4'd0);
    // Moves use the live switches; sw_ok is only a registered hint for the overlay.
    assign move_valid  = in_game && (sw == 16'h0000) && move_single;

    assign quiz_ok = (state[ST_Q1] && sw == ANS_Q1)
                   | (state[ST_Q2] && sw == ANS_Q2)
                   | (state[ST_Q3] && sw == ANS_Q3);

    always_comb begin
        case (dirs)
            4'b0010: move_code = DIR_RIGHT;
            4'b0100: move_code = DIR_DOWN;
            4'b1000: move_code = DIR_LEFT;
            default: move_code = DIR_UP;
        endcase
    end

    always_comb begin
        if (state[ST_G2])      seq_sel = SEQ_G2;
        else if (state[ST_G3]) seq_sel = SEQ_G3;
        else                   seq_sel = SEQ_G1;
    end

    fpsr_seq_checker #(
        .SEQ_LEN  (SEQ_LEN),
        .MAX_MISS (MAX_MISS)
    ) u_seq_checker (
        .clk        (ClkPort),
        .rst_n      (Reset_n),
        .clear      (!in_game),
        .move_valid (move_valid),
        .move_code  (move_code),
        .seq        (seq_sel),
        .seq_done   (seq_done),
        .forfeit    (forfeit)
    );

    // NOTE: every signal written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_n = state;
        score_n = score;
        case (state)
            S_INIT: begin
                if (btn_c) begin
                    state_n = S_Q1;
                    score_n = '0;
                end
            end
            S_Q1, S_Q2, S_Q3: begin
                if (btn_c) begin
                    state_n = state << 1;
                    if (quiz_ok) score_n = sat_add(score, 2'd1);
                end
            end
            S_G1, S_G2, S_G3: begin
                if (seq_done) begin
                    state_n = state << 1;
                    score_n = sat_add(score, 2'd2);
                end else if (forfeit) begin
                    state_n = state << 1;
                end
            end
            S_DONE: begin
                if (btn_c) state_n = S_INIT;
            end
            default: state_n = S_INIT;
        endcase
    end

    always_ff @(posedge ClkPort) begin
        if (!Reset_n) begin
            state <= S_INIT;
            score <= '0;
            sw_ok <= 1'b0;
        end else begin
            state <= state_n;
            score <= score_n;
            sw_ok <= (sw == 16'h0000);
        end
    end

    assign q_Init = state[ST_INIT];
    assign q_Q1   = state[ST_Q1];
    assign q_Q2   = state[ST_Q2];
    assign q_Q3   = state[ST_Q3];
    assign q_G1   = state[ST_G1];
    assign q_G2   = state[ST_G2];
    assign q_G3   = state[ST_G3];
    assign q_Done = state[ST_DONE];

endmodule

// File: tb/tb_fpsr_game_fsm.sv
// Self-checking bench for fpsr_game_fsm: scripted scenarios plus randomized
// play, compared cycle by cycle against a behavioural model of the game rules.
module tb_fpsr_game_fsm;
    import fpsr_pkg::*;

    localparam int SEQ_LEN  = 4;
    localparam int MAX_MISS = 3;

    logic        ClkPort = 1'b0;
    logic        Reset_n = 1'b0;
    logic        btn_c   = 1'b0;
    logic        up      = 1'b0;
    logic        right   = 1'b0;
    logic        down    = 1'b0;
    logic        left    = 1'b0;
    logic [15:0] sw      = 16'h0000;
    logic        q_Init, q_Q1, q_Q2, q_Q3, q_G1, q_G2, q_G3, q_Done;
    logic        sw_ok;
    logic [7:0]  score;

    fpsr_game_fsm dut (
        .ClkPort (ClkPort),
        .Reset_n (Reset_n),
        .btn_c   (btn_c),
        .up      (up),
        .right   (right),
        .down    (down),
        .left    (left),
        .sw      (sw),
        .q_Init  (q_Init),
        .q_Q1    (q_Q1),
        .q_Q2    (q_Q2),
        .q_Q3    (q_Q3),
        .q_G1    (q_G1),
        .q_G2    (q_G2),
        .q_G3    (q_G3),
        .q_Done  (q_Done),
        .sw_ok   (sw_ok),
        .score   (score)
    );

    always #5 ClkPort = ~ClkPort;

    // Reference model: mode 0=INIT, 1..3=quiz, 4..6=game, 7=DONE.
    logic [15:0] ans_tab [0:2];
    logic [7:0]  seq_tab [0:2];
    int m_mode, m_score, m_idx, m_miss;
    bit m_swok;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic int sat(input int v);
        return (v > 255) ? 255 : v;
    endfunction

    function automatic int next_want();
        return (seq_tab[m_mode-4] >> (2 * m_idx)) & 3;
    endfunction

    task automatic model_step(input bit b, input bit [3:0] d, input bit [15:0] s, input bit rn);
        int code;
        if (!rn) begin
            m_mode = 0; m_score = 0; m_idx = 0; m_miss = 0; m_swok = 0;
            return;
        end
        m_swok = (s == 16'h0000);
        if (m_mode == 0) begin
            if (b) begin m_mode = 1; m_score = 0; end
        end else if (m_mode <= 3) begin
            if (b) begin
                if (s == ans_tab[m_mode-1]) m_score = sat(m_score + 1);
                m_mode++;
            end
        end else if (m_mode <= 6) begin
            if (s == 16'h0000 && $countones(d) == 1) begin
                code = 0;
                for (int i = 0; i < 4; i++) if (d[i]) code = i;
                if (code == next_want()) begin
                    if (m_idx == SEQ_LEN - 1) begin
                        m_score = sat(m_score + 2);
                        m_idx = 0; m_miss = 0; m_mode++;
                    end else begin
                        m_idx++;
                    end
                end else begin
                    m_idx = 0;
                    m_miss++;
                    if (m_miss == MAX_MISS) begin m_miss = 0; m_mode++; end
                end
            end
        end else if (b) begin
            m_mode = 0;
        end
    endtask

    // d bit order: [0]=up, [1]=right, [2]=down, [3]=left.
    task automatic cycle(input bit b, input bit [3:0] d, input bit [15:0] s, input bit rn, input string tag);
        @(negedge ClkPort);
        btn_c = b;
        {left, down, right, up} = d;
        sw = s;
        Reset_n = rn;
        model_step(b, d, s, rn);
        @(posedge ClkPort);
        #1;
        check({tag, ":state"}, {24'b0, q_Done, q_G3, q_G2, q_G1, q_Q3, q_Q2, q_Q1, q_Init},
              32'(1) << m_mode);
        check({tag, ":score"}, {24'b0, score}, 32'(m_score));
        check({tag, ":sw_ok"}, {31'b0, sw_ok}, {31'b0, m_swok});
    endtask

    task automatic move(input int code, input bit [15:0] s, input string tag);
        cycle(1'b0, 4'b1 << code, s, 1'b1, tag);
        cycle(1'b0, 4'b0000, s, 1'b1, {tag, "_gap"});
    endtask

    task automatic play_game(input string tag);
        for (int i = 0; i < SEQ_LEN; i++) move(next_want(), 16'h0000, tag);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit b;
        bit [3:0] d;
        bit [15:0] s;
        bit rn;
        int r;
        logic [7:0] a;
        logic [1:0] inc;

        ans_tab[0] = 16'h0005; ans_tab[1] = 16'h00A0; ans_tab[2] = 16'h8001;
        seq_tab[0] = 8'b00_01_10_11; seq_tab[1] = 8'b11_11_00_01; seq_tab[2] = 8'b10_00_11_01;
        m_mode = 0; m_score = 0; m_idx = 0; m_miss = 0; m_swok = 0;

        cycle(1'b0, 4'b0000, 16'h0000, 1'b0, "rst");
        cycle(1'b0, 4'b0000, 16'h0000, 1'b0, "rst");

        // Quiz pass with Q3 answered wrong.
        cycle(1'b1, 4'b0000, 16'h0000, 1'b1, "init_btn");
        cycle(1'b1, 4'b0000, 16'h0005, 1'b1, "q1_ok");
        cycle(1'b1, 4'b0000, 16'h00A0, 1'b1, "q2_ok");
        cycle(1'b1, 4'b0000, 16'h0000, 1'b1, "q3_bad");
        check("enter_g1", {31'b0, q_G1}, 32'd1);
        check("score_after_quiz", {24'b0, score}, 32'd2);

        // Moves with a switch raised are ignored.
        for (int i = 0; i < 4; i++) move(i, 16'h0001, "g1_sw_on");
        check("g1_held", {31'b0, q_G1}, 32'd1);
        play_game("g1_play");
        check("enter_g2", {31'b0, q_G2}, 32'd1);

        // Simultaneous directions ignored, then three misses forfeit.
        cycle(1'b0, 4'b1001, 16'h0000, 1'b1, "g2_dual");
        for (int i = 0; i < MAX_MISS; i++) move(DIR_UP, 16'h0000, "g2_miss");
        check("forfeit_g3", {31'b0, q_G3}, 32'd1);
        check("forfeit_score", {24'b0, score}, 32'd4);

        play_game("g3_play");
        check("done", {31'b0, q_Done}, 32'd1);
        cycle(1'b0, 4'b0001, 16'h0000, 1'b1, "done_dir");
        cycle(1'b1, 4'b0000, 16'h0000, 1'b1, "done_btn");
        check("done_keeps_score", {24'b0, score}, 32'd6);
        cycle(1'b1, 4'b0000, 16'h0000, 1'b1, "restart");
        check("restart_clears", {24'b0, score}, 32'd0);

        // All quiz answers right, clear G1, then reset from G2 with score 5.
        cycle(1'b1, 4'b0000, 16'h0005, 1'b1, "q1_ok");
        cycle(1'b1, 4'b0000, 16'h00A0, 1'b1, "q2_ok");
        cycle(1'b1, 4'b0000, 16'h8001, 1'b1, "q3_ok");
        play_game("g1_play2");
        check("g2_score5", {24'b0, score}, 32'd5);
        cycle(1'b0, 4'b0000, 16'h0000, 1'b0, "mid_rst");
        cycle(1'b0, 4'b0000, 16'h0000, 1'b0, "mid_rst");
        for (int i = 0; i < 4; i++) cycle(1'b0, 4'b1 << i, 16'h0000, 1'b1, "init_dir");

        // Entering Q1 always clears the score, so saturation is checked on the adder.
        for (int i = 0; i < 8; i++) begin
            a   = (i < 4) ? 8'(252 + i) : 8'($urandom_range(0, 255));
            inc = 2'((i % 2) + 1);
            check("sat_add", {24'b0, sat_add(a, inc)}, 32'(sat(int'(a) + int'(inc))));
        end

        for (int i = 0; i < 4000; i++) begin
            b = ($urandom_range(0, 3) == 0);
            r = $urandom_range(0, 9);
            if (r < 6)      s = 16'h0000;
            else if (r < 9) s = ans_tab[$urandom_range(0, 2)];
            else            s = 16'($urandom);
            r = $urandom_range(0, 9);
            if (r < 3)      d = 4'b0000;
            else if (r < 8) d = 4'b1 << ((m_mode >= 4 && m_mode <= 6 && $urandom_range(0, 1) == 1)
                                         ? next_want() : $urandom_range(0, 3));
            else            d = 4'($urandom);
            rn = ($urandom_range(0, 299) != 0);
            cycle(b, d, s, rn, "rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
